// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one shared memory between instruction fetch and data access. Data has priority,
// fetch starvation is bounded, and each read response is routed back to its issuer.
module imem_dmem_arbiter #(
    parameter int unsigned AWIDTH     = 32,
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam logic [2:0] LatInit   = 3'(MEM_LAT);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic {StIdle, StRdWait} state_e;

    state_e            r_state;
    logic [2:0]        r_cnt;
    logic              r_owner_d;
    logic [3:0]        r_starve;
    logic [AWIDTH-1:0] r_addr;

    logic w_resp;
    logic w_elig;
    logic w_if_prio;
    logic w_d_gnt;
    logic w_if_gnt;
    logic w_rd_gnt;

    // The response cycle of an outstanding read is also a grant slot, so reads can overlap.
    assign w_resp    = (r_state == StRdWait) && (r_cnt == 3'd1);
    assign w_elig    = !rst && ((r_state == StIdle) || w_resp);
    assign w_if_prio = if_req_i && (r_starve == StarveMax);
    assign w_d_gnt   = w_elig && d_req_i && !w_if_prio;
    assign w_if_gnt  = w_elig && if_req_i && !w_d_gnt;
    assign w_rd_gnt  = w_if_gnt || (w_d_gnt && !d_we_i);

    always_comb begin
        if_gnt_o       = w_if_gnt;
        d_gnt_o        = w_d_gnt;
        mem_addr_o     = r_addr;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (w_d_gnt) begin
            mem_addr_o     = d_addr_i;
            mem_read_en_o  = !d_we_i;
            mem_write_en_o = d_we_i;
            mem_data_o     = d_we_i ? d_wdata_i : '0;
        end else if (w_if_gnt) begin
            mem_addr_o    = if_addr_i;
            mem_read_en_o = 1'b1;
        end
    end

    always_comb begin
        if_rvalid_o = w_resp && !r_owner_d && !rst;
        d_rvalid_o  = w_resp && r_owner_d && !rst;
        if_rdata_o  = if_rvalid_o ? mem_data_i : '0;
        d_rdata_o   = d_rvalid_o ? mem_data_i : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= 3'd0;
            r_owner_d <= 1'b0;
            r_starve  <= 4'd0;
            r_addr    <= '0;
        end else begin
            if (w_d_gnt) begin
                r_addr <= d_addr_i;
            end else if (w_if_gnt) begin
                r_addr <= if_addr_i;
            end

            if (w_if_gnt) begin
                r_starve <= 4'd0;
            end else if (w_d_gnt) begin
                if (!if_req_i) begin
                    r_starve <= 4'd0;
                end else if (r_starve != StarveMax) begin
                    r_starve <= r_starve + 4'd1;
                end
            end

            if (w_rd_gnt) begin
                r_state   <= StRdWait;
                r_cnt     <= LatInit;
                r_owner_d <= w_d_gnt;
            end else if (r_state == StRdWait) begin
                r_cnt <= r_cnt - 3'd1;
                if (w_resp) begin
                    r_state <= StIdle;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// behind a latency-matched memory model and a scoreboard of expected read responses.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b1;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b1;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic        u1_if_gnt, u1_if_rvalid, u1_d_gnt, u1_d_rvalid, u1_rd, u1_wr;
    logic [31:0] u1_if_rdata, u1_d_rdata, u1_maddr, u1_mdata, m1_data;
    logic        u3_if_gnt, u3_if_rvalid, u3_d_gnt, u3_d_rvalid, u3_rd, u3_wr;
    logic [31:0] u3_if_rdata, u3_d_rdata, u3_maddr, u3_mdata, m3_data, p0, p1;

    int unsigned cyc = 0;
    int          sel = 1;
    int          n_err = 0;
    int          n_chk = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int unsigned due;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_dmem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(u1_if_gnt),
        .if_rvalid_o(u1_if_rvalid), .if_rdata_o(u1_if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(u1_d_gnt), .d_rvalid_o(u1_d_rvalid), .d_rdata_o(u1_d_rdata),
        .mem_addr_o(u1_maddr), .mem_data_o(u1_mdata), .mem_read_en_o(u1_rd),
        .mem_write_en_o(u1_wr), .mem_data_i(m1_data)
    );

    imem_dmem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(u3_if_gnt),
        .if_rvalid_o(u3_if_rvalid), .if_rdata_o(u3_if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(u3_d_gnt), .d_rvalid_o(u3_d_rvalid), .d_rdata_o(u3_d_rdata),
        .mem_addr_o(u3_maddr), .mem_data_o(u3_mdata), .mem_read_en_o(u3_rd),
        .mem_write_en_o(u3_wr), .mem_data_i(m3_data)
    );

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory returns fdat(addr) MEM_LAT cycles after a read strobe, junk otherwise.
    always @(posedge clk) begin
        m1_data <= u1_rd ? fdat(u1_maddr) : 32'hBADD_0000;
        p0      <= u3_rd ? fdat(u3_maddr) : 32'hBADD_0003;
        p1      <= p0;
        m3_data <= p1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input logic [31:0] addr, input int unsigned due);
        exp_t e;
        e.is_d = is_d;
        e.data = fdat(addr);
        e.due  = due;
        q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: the selected instance must respond exactly when and where the scoreboard says.
    always @(negedge clk) begin
        logic        rv_if, rv_d;
        logic [31:0] rd_if, rd_d, ed;
        bit          exp_if, exp_d;
        rv_if  = (sel == 1) ? u1_if_rvalid : u3_if_rvalid;
        rv_d   = (sel == 1) ? u1_d_rvalid : u3_d_rvalid;
        rd_if  = (sel == 1) ? u1_if_rdata : u3_if_rdata;
        rd_d   = (sel == 1) ? u1_d_rdata : u3_d_rdata;
        exp_if = 1'b0;
        exp_d  = 1'b0;
        ed     = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].is_d) exp_d = 1'b1;
            else exp_if = 1'b1;
            ed = q[0].data;
            void'(q.pop_front());
        end
        chk("if_rvalid", {63'd0, rv_if}, {63'd0, exp_if});
        chk("d_rvalid", {63'd0, rv_d}, {63'd0, exp_d});
        chk("if_rdata", {32'd0, rd_if}, exp_if ? {32'd0, ed} : 64'd0);
        chk("d_rdata", {32'd0, rd_d}, exp_d ? {32'd0, ed} : 64'd0);
    end

    initial begin
        // Reset with both requests high: nothing may be granted.
        @(negedge clk);
        chk("rst_if_gnt", {63'd0, u1_if_gnt}, 64'd0);
        chk("rst_d_gnt", {63'd0, u1_d_gnt}, 64'd0);
        chk("rst_maddr", {32'd0, u1_maddr}, 64'd0);
        chk("rst_mdata", {32'd0, u1_mdata}, 64'd0);
        chk("rst_rd", {63'd0, u1_rd}, 64'd0);
        chk("rst_wr", {63'd0, u1_wr}, 64'd0);
        next();
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("rst_starve", {60'd0, u1.r_starve}, 64'd0);

        // Single fetch, MEM_LAT=1.
        next(); if_req = 1'b1; if_addr = 32'h0100_0000;
        @(negedge clk);
        chk("t1_if_gnt", {63'd0, u1_if_gnt}, 64'd1);
        chk("t1_d_gnt", {63'd0, u1_d_gnt}, 64'd0);
        chk("t1_maddr", {32'd0, u1_maddr}, 64'h0100_0000);
        chk("t1_rd", {63'd0, u1_rd}, 64'd1);
        chk("t1_wr", {63'd0, u1_wr}, 64'd0);
        push(1'b0, 32'h0100_0000, cyc + 1);
        next(); if_req = 1'b0;
        @(negedge clk);
        chk("t1_if_gnt_off", {63'd0, u1_if_gnt}, 64'd0);
        chk("t1_rd_off", {63'd0, u1_rd}, 64'd0);
        chk("t1_maddr_hold", {32'd0, u1_maddr}, 64'h0100_0000);

        // Simultaneous fetch and data read: data first, fetch in the data response cycle.
        next(); if_req = 1'b1; if_addr = 32'h0100_0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0100;
        @(negedge clk);
        chk("t2_d_gnt", {63'd0, u1_d_gnt}, 64'd1);
        chk("t2_if_gnt", {63'd0, u1_if_gnt}, 64'd0);
        chk("t2_maddr", {32'd0, u1_maddr}, 64'h0100_0100);
        chk("t2_rd", {63'd0, u1_rd}, 64'd1);
        push(1'b1, 32'h0100_0100, cyc + 1);
        next(); d_req = 1'b0;
        @(negedge clk);
        chk("t2_if_gnt2", {63'd0, u1_if_gnt}, 64'd1);
        chk("t2_d_gnt2", {63'd0, u1_d_gnt}, 64'd0);
        chk("t2_maddr2", {32'd0, u1_maddr}, 64'h0100_0010);
        push(1'b0, 32'h0100_0010, cyc + 1);
        next(); if_req = 1'b0;
        @(negedge clk);
        chk("t2_if_gnt_off", {63'd0, u1_if_gnt}, 64'd0);

        // Data write, then a fetch the following cycle.
        next(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0200; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t3_d_gnt", {63'd0, u1_d_gnt}, 64'd1);
        chk("t3_wr", {63'd0, u1_wr}, 64'd1);
        chk("t3_rd", {63'd0, u1_rd}, 64'd0);
        chk("t3_mdata", {32'd0, u1_mdata}, 64'hDEAD_BEEF);
        chk("t3_maddr", {32'd0, u1_maddr}, 64'h0100_0200);
        next(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        if_req = 1'b1; if_addr = 32'h0100_0020;
        @(negedge clk);
        chk("t3_if_gnt", {63'd0, u1_if_gnt}, 64'd1);
        chk("t3_mdata0", {32'd0, u1_mdata}, 64'd0);
        chk("t3_wr0", {63'd0, u1_wr}, 64'd0);
        push(1'b0, 32'h0100_0020, cyc + 1);
        next(); if_req = 1'b0;
        @(negedge clk);
        chk("t3_maddr_hold", {32'd0, u1_maddr}, 64'h0100_0020);
        chk("t3_rd_off", {63'd0, u1_rd}, 64'd0);

        // Starvation: four data writes, then the fetch wins the fifth slot.
        next(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0300; d_wdata = 32'h11;
        if_req = 1'b1; if_addr = 32'h0100_0040;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next();
            @(negedge clk);
            chk($sformatf("t4_starve%0d", k), {60'd0, u1.r_starve}, 64'(k));
            chk($sformatf("t4_d_gnt%0d", k), {63'd0, u1_d_gnt}, (k < 4) ? 64'd1 : 64'd0);
            chk($sformatf("t4_if_gnt%0d", k), {63'd0, u1_if_gnt}, (k == 4) ? 64'd1 : 64'd0);
            if (k == 4) push(1'b0, 32'h0100_0040, cyc + 1);
        end
        next(); if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        @(negedge clk);
        chk("t4_starve_clr", {60'd0, u1.r_starve}, 64'd0);
        next();
        @(negedge clk);
        chk("sb_drain1", 64'(q.size()), 64'd0);

        // Switch to the MEM_LAT=3 instance through a reset.
        next(); rst = 1'b1; sel = 3;
        next();
        next(); rst = 1'b0;
        next(); if_req = 1'b1; if_addr = 32'h0200_0000;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                next();
                if (k == 7) if_req = 1'b0;
                else if (k % 3 == 1) if_addr = if_addr + 32'h10;
            end
            @(negedge clk);
            chk($sformatf("t5_if_gnt%0d", k), {63'd0, u3_if_gnt},
                (k % 3 == 0 && k <= 6) ? 64'd1 : 64'd0);
            chk($sformatf("t5_rd%0d", k), {63'd0, u3_rd},
                (k % 3 == 0 && k <= 6) ? 64'd1 : 64'd0);
            if (k % 3 == 0 && k <= 6) push(1'b0, if_addr, cyc + 3);
        end

        // A write waits out RD_WAIT and is granted in the response cycle.
        next(); if_req = 1'b1; if_addr = 32'h0200_0100;
        @(negedge clk);
        chk("t6_if_gnt", {63'd0, u3_if_gnt}, 64'd1);
        push(1'b0, 32'h0200_0100, cyc + 3);
        for (int k = 1; k < 4; k++) begin
            next();
            if (k == 1) begin
                if_req = 1'b0;
                d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0400; d_wdata = 32'h22;
            end
            @(negedge clk);
            chk($sformatf("t6_d_gnt%0d", k), {63'd0, u3_d_gnt}, (k == 3) ? 64'd1 : 64'd0);
            chk($sformatf("t6_wr%0d", k), {63'd0, u3_wr}, (k == 3) ? 64'd1 : 64'd0);
        end
        next(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        @(negedge clk);
        chk("t6_d_gnt_off", {63'd0, u3_d_gnt}, 64'd0);

        // Reset one cycle into an outstanding read: the response must never appear.
        next(); if_req = 1'b1; if_addr = 32'h0200_0200;
        @(negedge clk);
        chk("t7_if_gnt", {63'd0, u3_if_gnt}, 64'd1);
        next(); if_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("t7_if_gnt0", {63'd0, u3_if_gnt}, 64'd0);
        chk("t7_d_gnt0", {63'd0, u3_d_gnt}, 64'd0);
        chk("t7_maddr0", {32'd0, u3_maddr}, 64'd0);
        chk("t7_mdata0", {32'd0, u3_mdata}, 64'd0);
        chk("t7_rd0", {63'd0, u3_rd}, 64'd0);
        chk("t7_wr0", {63'd0, u3_wr}, 64'd0);
        chk("t7_if_rvalid0", {63'd0, u3_if_rvalid}, 64'd0);
        next(); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next();
            @(negedge clk);
            chk($sformatf("t7_no_rvalid%0d", k), {63'd0, u3_if_rvalid}, 64'd0);
        end
        chk("sb_drain2", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
